// File: rtl/intersection_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intersection_scheduler_pkg
// Purpose  : Shared codes for the intersection scheduler: 3-bit state codes,
//            one-hot lamp codes {R,Y,G} and road direction codes, plus a
//            helper that decodes a road's lamp from a state code.
// Revision : 1.0 - initial release
// ============================================================================
package intersection_scheduler_pkg;

    // State codes (3'd7 is unused and recovers to ST_AR_EW)
    localparam logic [2:0] ST_NS_G  = 3'd0;
    localparam logic [2:0] ST_NS_Y  = 3'd1;
    localparam logic [2:0] ST_AR_NS = 3'd2;
    localparam logic [2:0] ST_EW_G  = 3'd3;
    localparam logic [2:0] ST_EW_Y  = 3'd4;
    localparam logic [2:0] ST_AR_EW = 3'd5;
    localparam logic [2:0] ST_WALK  = 3'd6;

    // One-hot lamp codes {R,Y,G}
    localparam logic [2:0] LT_R = 3'b100;
    localparam logic [2:0] LT_Y = 3'b010;
    localparam logic [2:0] LT_G = 3'b001;

    // Road directions
    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    // Lamp shown by road 'dir' while the controller is in state 'st'.
    // Anything other than that road's green or yellow is red, which keeps
    // both roads red in all-red, walk and unused codes.
    function automatic logic [2:0] light_of(input logic [2:0] st, input logic dir);
        logic [2:0] w_g;
        logic [2:0] w_y;
        w_g = (dir == DIR_NS) ? ST_NS_G : ST_EW_G;
        w_y = (dir == DIR_NS) ? ST_NS_Y : ST_EW_Y;
        if (st == w_g) return LT_G;
        if (st == w_y) return LT_Y;
        return LT_R;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intersection_scheduler_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : phase_timer
// Purpose  : Per-phase cycle counter. Synchronous clear, saturating up-count.
// Ports    : clk   - rising-edge clock
//            rst   - asynchronous active-high reset (count -> 0)
//            clr   - synchronous clear, pulsed on every state change
//            count - cycles spent in the current phase (saturates)
// Revision : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (r_count != {CNT_W{1'b1}}) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : intersection_scheduler
// Purpose  : Moore controller for a two-road (NS/EW) intersection with a
//            pedestrian walk phase. One road green at a time, yellow and
//            all-red clearance, demand-extended green, all-red walk phase.
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous active-high reset
//            ns_car   - NS vehicle present (level)
//            ew_car   - EW vehicle present (level)
//            ped_btn  - pedestrian button (level, synchronous)
//            ns_light - NS lamp, one-hot {R,Y,G}
//            ew_light - EW lamp, one-hot {R,Y,G}
//            walk     - walk lamp
//            ped_wait - pedestrian request pending
//            phase    - current state code (debug)
// Revision : 1.0 - initial release
// ============================================================================
module intersection_scheduler
    import intersection_scheduler_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_btn,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_wait,
    output logic [2:0] phase
);

    // Exit thresholds: a phase of N cycles leaves on the edge where t == N-1
    localparam logic [CNT_W-1:0] C_GMIN_T = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] C_GMAX_T = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] C_YEL_T  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] C_AR_T   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] C_WALK_T = CNT_W'(WALK_T - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] w_t;
    logic             w_clr;
    logic             r_ped_pending;
    logic             r_last_dir;
    logic [2:0]       w_green_opp;
    logic [2:0]       r_ns_light;
    logic [2:0]       r_ew_light;
    logic             r_walk;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .count (w_t)
    );

    // Timer restarts at 0 on the first cycle of every new state
    assign w_clr = (w_next != r_state);

    // Green goes to the road that did not clear most recently
    assign w_green_opp = (r_last_dir == DIR_NS) ? ST_EW_G : ST_NS_G;

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_NS_G: begin
                if ((ew_car | r_ped_pending) && (w_t >= C_GMIN_T) &&
                    (!ns_car || (w_t >= C_GMAX_T)))
                    w_next = ST_NS_Y;
            end
            ST_EW_G: begin
                if ((ns_car | r_ped_pending) && (w_t >= C_GMIN_T) &&
                    (!ew_car || (w_t >= C_GMAX_T)))
                    w_next = ST_EW_Y;
            end
            ST_NS_Y:  if (w_t >= C_YEL_T) w_next = ST_AR_NS;
            ST_EW_Y:  if (w_t >= C_YEL_T) w_next = ST_AR_EW;
            ST_AR_NS, ST_AR_EW: begin
                if (w_t >= C_AR_T)
                    w_next = r_ped_pending ? ST_WALK : w_green_opp;
            end
            ST_WALK:  if (w_t >= C_WALK_T) w_next = w_green_opp;
            default:  w_next = ST_AR_EW;
        endcase
    end

    // ---------------- state, request and direction registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_AR_EW;
            r_ped_pending <= 1'b0;
            r_last_dir    <= DIR_EW;
            r_ns_light    <= LT_R;
            r_ew_light    <= LT_R;
            r_walk        <= 1'b0;
        end else begin
            r_state <= w_next;

            // Clearing on entry to WALK takes priority over a same-cycle press;
            // presses during WALK are ignored.
            if (w_next == ST_WALK && r_state != ST_WALK)
                r_ped_pending <= 1'b0;
            else if (ped_btn && r_state != ST_WALK)
                r_ped_pending <= 1'b1;

            if (w_next == ST_AR_NS && r_state != ST_AR_NS)
                r_last_dir <= DIR_NS;
            else if (w_next == ST_AR_EW && r_state != ST_AR_EW)
                r_last_dir <= DIR_EW;

            // Lamps are decoded from the next state so they update on the
            // same edge as the state register.
            r_ns_light <= light_of(w_next, DIR_NS);
            r_ew_light <= light_of(w_next, DIR_EW);
            r_walk     <= (w_next == ST_WALK);
        end
    end

    assign ns_light = r_ns_light;
    assign ew_light = r_ew_light;
    assign walk     = r_walk;
    assign ped_wait = r_ped_pending;
    assign phase    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_intersection_scheduler
// Purpose  : Self-checking bench for intersection_scheduler. A reference
//            model tracks (phase kind, owning road, age, pending request)
//            and predicts lamps, walk, ped_wait and the phase code.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intersection_scheduler;
    import intersection_scheduler_pkg::*;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 10;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 3;

    localparam int PH_GREEN  = 0;
    localparam int PH_YELLOW = 1;
    localparam int PH_ALLRED = 2;
    localparam int PH_WALK   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ns_car = 1'b0;
    logic       ew_car = 1'b0;
    logic       ped_btn = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_wait;
    logic [2:0] phase;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: road 0 = NS, 1 = EW. In all-red and walk, m_road is
    // the road that cleared last.
    int m_phase;
    int m_road;
    int m_age;
    bit m_pending;

    intersection_scheduler #(
        .CNT_W     (8),
        .GREEN_MIN (GREEN_MIN),
        .GREEN_MAX (GREEN_MAX),
        .YELLOW_T  (YELLOW_T),
        .ALLRED_T  (ALLRED_T),
        .WALK_T    (WALK_T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ns_car   (ns_car),
        .ew_car   (ew_car),
        .ped_btn  (ped_btn),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .ped_wait (ped_wait),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_phase   = PH_ALLRED;
        m_road    = 1;
        m_age     = 0;
        m_pending = 1'b0;
    endtask

    function automatic logic [2:0] exp_lamp(input int road);
        if (m_road == road && m_phase == PH_GREEN)  return 3'b001;
        if (m_road == road && m_phase == PH_YELLOW) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] exp_code();
        case (m_phase)
            PH_GREEN:  return (m_road == 0) ? ST_NS_G  : ST_EW_G;
            PH_YELLOW: return (m_road == 0) ? ST_NS_Y  : ST_EW_Y;
            PH_ALLRED: return (m_road == 0) ? ST_AR_NS : ST_AR_EW;
            default:   return ST_WALK;
        endcase
    endfunction

    // Advance the model by one clock using the inputs sampled on that edge
    task automatic model_step(input bit nsc, input bit ewc, input bit btn);
        int  nphase;
        int  nroad;
        bit  own;
        bit  other;
        nphase = m_phase;
        nroad  = m_road;
        case (m_phase)
            PH_GREEN: begin
                own   = (m_road == 0) ? nsc : ewc;
                other = (m_road == 0) ? ewc : nsc;
                if ((other || m_pending) && (m_age + 1 >= GREEN_MIN) &&
                    (!own || (m_age + 1 >= GREEN_MAX)))
                    nphase = PH_YELLOW;
            end
            PH_YELLOW: if (m_age + 1 >= YELLOW_T) nphase = PH_ALLRED;
            PH_ALLRED: begin
                if (m_age + 1 >= ALLRED_T) begin
                    if (m_pending) nphase = PH_WALK;
                    else begin nphase = PH_GREEN; nroad = 1 - m_road; end
                end
            end
            default: begin
                if (m_age + 1 >= WALK_T) begin
                    nphase = PH_GREEN; nroad = 1 - m_road;
                end
            end
        endcase
        if (nphase == PH_WALK && m_phase != PH_WALK) m_pending = 1'b0;
        else if (btn && m_phase != PH_WALK)          m_pending = 1'b1;
        m_age   = (nphase == m_phase && nroad == m_road) ? m_age + 1 : 0;
        m_phase = nphase;
        m_road  = nroad;
    endtask

    task automatic check_all();
        check("ns_light", 32'(ns_light), 32'(exp_lamp(0)));
        check("ew_light", 32'(ew_light), 32'(exp_lamp(1)));
        check("walk",     32'(walk),     32'(m_phase == PH_WALK));
        check("ped_wait", 32'(ped_wait), 32'(m_pending));
        check("phase",    32'(phase),    32'(exp_code()));
        check("invariant", 32'((ns_light != 3'b100 && ew_light != 3'b100) ||
                               (walk && (ns_light != 3'b100 || ew_light != 3'b100))), 32'd0);
    endtask

    // Modes: 0 idle, 1 EW car only, 2 both cars, 3 single ped pulse,
    // 4 ped held + EW car, 5 random
    task automatic run_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            check_all();
            case (mode)
                0: begin ns_car = 0; ew_car = 0; ped_btn = 0; end
                1: begin ns_car = 0; ew_car = 1; ped_btn = 0; end
                2: begin ns_car = 1; ew_car = 1; ped_btn = 0; end
                3: begin ns_car = 0; ew_car = 0; ped_btn = (i == 10); end
                4: begin ns_car = 0; ew_car = 1; ped_btn = 1; end
                default: begin
                    ns_car  = ($urandom_range(0, 2) != 0);
                    ew_car  = ($urandom_range(0, 2) != 0);
                    ped_btn = ($urandom_range(0, 11) == 0);
                end
            endcase
            @(posedge clk);
            model_step(ns_car, ew_car, ped_btn);
            @(negedge clk);
        end
    endtask

    // Assert reset for a couple of cycles and release at a falling edge
    task automatic do_reset();
        rst = 1'b1; ns_car = 0; ew_car = 0; ped_btn = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit found;
        model_reset();
        @(negedge clk);
        do_reset();
        run_cycles(60, 0);            // idle: NS rests green

        do_reset();
        run_cycles(40, 1);            // EW demand only

        do_reset();
        run_cycles(30, 3);            // single pedestrian pulse

        do_reset();
        run_cycles(80, 4);            // pedestrian held with EW demand

        do_reset();
        run_cycles(70, 2);            // both roads busy

        // Wait (bounded) for EW yellow, then reset between clock edges
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_phase == PH_YELLOW && m_road == 1) found = 1'b1;
            else run_cycles(1, 2);
        end
        check("reach_ew_yellow", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_ns_red", 32'(ns_light), 32'(LT_R));
        check("async_ew_red", 32'(ew_light), 32'(LT_R));
        check("async_walk",   32'(walk),     32'd0);
        check("async_phase",  32'(phase),    32'(ST_AR_EW));
        ns_car = 0; ew_car = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_cycles(30, 0);            // idle sequence repeats after reset

        do_reset();
        run_cycles(600, 5);           // random traffic and pedestrians

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
